// File: rtl/seq_pattern_pkg.sv
// ---------------------------------------------------------------------------
// seq_pattern_pkg
// Shared types and helpers for the serial "101" pattern transmit path.
//   tx_state_t  : transmit FSM states (IDLE, SHIFT, GAP)
//   trk_state_t : overlapping "101" tracker states (S0, S1, S10)
//   cntWidth()  : counter width helper, never returns less than 1 bit
// ---------------------------------------------------------------------------
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10
  } trk_state_t;

  // Bits needed to hold values 0..n-1; a 1-bit minimum keeps degenerate
  // parameterisations (n <= 1) from producing zero-width vectors.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_tracker.sv
// ---------------------------------------------------------------------------
// seq101_tracker
// Overlapping "101" detector sampling one bit per clock. Also used on its own
// as a reference model for the receive side.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high
//   bit_in      in   serial bit sampled every cycle
//   match_pulse out  one-cycle pulse, the cycle after the completing '1'
//   match_cnt   out  CNT_W-bit wrapping count of matches
// ---------------------------------------------------------------------------
module seq101_tracker
  import seq_pattern_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  trk_state_t r_state;
  logic       w_match;

  assign w_match = (r_state == S10) && bit_in;

  // A completing '1' lands in S1, not S0, so "10101" counts twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
    end else begin
      case (r_state)
        S0:      r_state <= bit_in ? S1 : S0;
        S1:      r_state <= bit_in ? S1 : S10;
        S10:     r_state <= bit_in ? S1 : S0;
        default: r_state <= S0;
      endcase
      match_pulse <= w_match;
      if (w_match) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Accepts WIDTH-bit words over valid/ready and shifts them out MSB-first on a
// registered serial line, followed by GAP zero bits. An embedded "101"
// tracker watches the line and keeps a golden match count.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   data_in      in   word to transmit, sampled on accept
//   data_valid   in   data_in valid
//   data_ready   out  high only in IDLE
//   bit_out      out  serial line, 0 when not shifting
//   busy         out  high in SHIFT or GAP
//   match_pulse  out  one-cycle pulse per "101" seen on bit_out
//   match_cnt    out  wrapping count of "101" occurrences
// ---------------------------------------------------------------------------
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BIT_W = cntWidth(WIDTH);
  localparam int GAP_W = cntWidth(GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  // State literals are package-scoped because the GAP parameter shadows the
  // GAP state name inside this module.
  tx_state_t        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bitCnt;
  logic [GAP_W-1:0] r_gapCnt;
  logic             r_bitOut;
  logic             w_accept;

  assign w_accept   = data_valid && (r_state == seq_pattern_pkg::IDLE);
  assign data_ready = (r_state == seq_pattern_pkg::IDLE);
  assign busy       = (r_state != seq_pattern_pkg::IDLE);
  assign bit_out    = r_bitOut;

  // r_bitCnt counts bits still to come after the one on the line, so zero
  // marks the LSB cycle. r_shift holds only the not-yet-sent bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= seq_pattern_pkg::IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_gapCnt <= '0;
      r_bitOut <= 1'b0;
    end else begin
      case (r_state)
        seq_pattern_pkg::IDLE: begin
          if (w_accept) begin
            r_shift  <= {data_in[WIDTH-2:0], 1'b0};
            r_bitOut <= data_in[WIDTH-1];
            r_bitCnt <= BIT_LAST;
            r_state  <= seq_pattern_pkg::SHIFT;
          end else begin
            r_bitOut <= 1'b0;
          end
        end
        seq_pattern_pkg::SHIFT: begin
          if (r_bitCnt != '0) begin
            r_bitOut <= r_shift[WIDTH-1];
            r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
            r_bitCnt <= r_bitCnt - 1'b1;
          end else begin
            r_bitOut <= 1'b0;
            r_gapCnt <= GAP_LAST;
            r_state  <= (GAP > 0) ? seq_pattern_pkg::GAP : seq_pattern_pkg::IDLE;
          end
        end
        seq_pattern_pkg::GAP: begin
          r_bitOut <= 1'b0;
          if (r_gapCnt == '0) begin
            r_state <= seq_pattern_pkg::IDLE;
          end else begin
            r_gapCnt <= r_gapCnt - 1'b1;
          end
        end
        default: begin
          r_bitOut <= 1'b0;
          r_state  <= seq_pattern_pkg::IDLE;
        end
      endcase
    end
  end

  seq101_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (r_bitOut),
    .match_pulse(match_pulse),
    .match_cnt  (match_cnt)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
// Directed bench for seq_pattern_tx: a default instance (WIDTH=8, GAP=2), a
// GAP=0 instance for cross-boundary matches and a CNT_W=2 instance for wrap.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic clk = 1'b0;
  logic reset;

  logic [7:0]  dataIn, dataIn0, dataInW;
  logic        dataValid, dataValid0, dataValidW;
  logic        dataReady, dataReady0, dataReadyW;
  logic        bitOut, bitOut0, bitOutW;
  logic        busy, busy0, busyW;
  logic        matchPulse, matchPulse0, matchPulseW;
  logic [15:0] matchCnt, matchCnt0;
  logic [1:0]  matchCntW;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .GAP(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .data_in(dataIn), .data_valid(dataValid),
    .data_ready(dataReady), .bit_out(bitOut), .busy(busy),
    .match_pulse(matchPulse), .match_cnt(matchCnt)
  );

  seq_pattern_tx #(.WIDTH(8), .GAP(0), .CNT_W(16)) u_dutGap0 (
    .clk(clk), .reset(reset), .data_in(dataIn0), .data_valid(dataValid0),
    .data_ready(dataReady0), .bit_out(bitOut0), .busy(busy0),
    .match_pulse(matchPulse0), .match_cnt(matchCnt0)
  );

  seq_pattern_tx #(.WIDTH(8), .GAP(2), .CNT_W(2)) u_dutWrap (
    .clk(clk), .reset(reset), .data_in(dataInW), .data_valid(dataValidW),
    .data_ready(dataReadyW), .bit_out(bitOutW), .busy(busyW),
    .match_pulse(matchPulseW), .match_cnt(matchCntW)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one word to the selected instance and returns in the first
  // cycle after the accepting edge (the cycle carrying the MSB).
  task automatic applyStimulus(input int sel, input logic [7:0] word);
    logic rdy;
    bit   done;
    done = 1'b0;
    case (sel)
      0:       begin dataIn  = word; dataValid  = 1'b1; end
      1:       begin dataIn0 = word; dataValid0 = 1'b1; end
      default: begin dataInW = word; dataValidW = 1'b1; end
    endcase
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = (sel == 0) ? dataReady : (sel == 1) ? dataReady0 : dataReadyW;
      if (rdy) done = 1'b1;
      tick();
    end
    dataValid  = 1'b0;
    dataValid0 = 1'b0;
    dataValidW = 1'b0;
    if (!done) checkOutput("acceptTimeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic [7:0] sh;
    int n;

    reset = 1'b1;
    dataIn = '0;  dataIn0 = '0;  dataInW = '0;
    dataValid = 1'b0; dataValid0 = 1'b0; dataValidW = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      checkOutput("idleBit",   32'(bitOut),    32'(0));
      checkOutput("idleReady", 32'(dataReady), 32'(1));
      checkOutput("idleBusy",  32'(busy),      32'(0));
      checkOutput("idleCnt",   32'(matchCnt),  32'(0));
      tick();
    end

    // Single word 8'hAA
    applyStimulus(0, 8'hAA);
    sh = 8'hAA;
    for (int c = 1; c <= 11; c++) begin
      checkOutput("aaBit",   32'(bitOut),     32'(sh[7]));
      checkOutput("aaPulse", 32'(matchPulse), 32'(c == 4 || c == 6 || c == 8));
      checkOutput("aaBusy",  32'(busy),       32'(c <= 10));
      checkOutput("aaReady", 32'(dataReady),  32'(c >= 11));
      sh = sh << 1;
      tick();
    end
    checkOutput("aaCnt", 32'(matchCnt), 32'(3));

    // Back-to-back 8'h05 then 8'hA0 with valid held high
    dataIn = 8'h05;
    dataValid = 1'b1;
    checkOutput("b2bReady", 32'(dataReady), 32'(1));
    tick();
    dataIn = 8'hA0;
    n = 1;
    while (dataReady !== 1'b1 && n < 30) begin
      if (n == 9) checkOutput("b2bPulse1", 32'(matchPulse), 32'(1));
      tick();
      n++;
    end
    checkOutput("b2bSpacing", 32'(n), 32'(11));
    tick();
    dataValid = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      checkOutput("b2bPulse2", 32'(matchPulse), 32'(m == 4));
      tick();
    end
    checkOutput("b2bCnt", 32'(matchCnt), 32'(5));

    // Asynchronous reset in cycle k+4 of 8'hFF
    applyStimulus(0, 8'hFF);
    tick();
    tick();
    tick();
    checkOutput("rstPreBit", 32'(bitOut), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstBit",   32'(bitOut),     32'(0));
    checkOutput("rstReady", 32'(dataReady),  32'(1));
    checkOutput("rstBusy",  32'(busy),       32'(0));
    checkOutput("rstPulse", 32'(matchPulse), 32'(0));
    checkOutput("rstCnt",   32'(matchCnt),   32'(0));
    tick();
    reset = 1'b0;
    tick();

    // Word after reset: 1,0,0,1,0,1,1,0 -> one match, pulse in cycle 7
    applyStimulus(0, 8'h96);
    sh = 8'h96;
    for (int c = 1; c <= 10; c++) begin
      checkOutput("postRstBit",   32'(bitOut),     32'(sh[7]));
      checkOutput("postRstPulse", 32'(matchPulse), 32'(c == 7));
      sh = sh << 1;
      tick();
    end
    checkOutput("postRstCnt", 32'(matchCnt), 32'(1));

    // GAP=0: 8'h01 then 8'h80, match spans the single idle zero
    applyStimulus(1, 8'h01);
    applyStimulus(1, 8'h80);
    checkOutput("gap0Bit",    32'(bitOut0),     32'(1));
    checkOutput("gap0PreCnt", 32'(matchCnt0),   32'(0));
    tick();
    checkOutput("gap0Pulse",  32'(matchPulse0), 32'(1));
    for (int c = 0; c < 10; c++) tick();
    checkOutput("gap0Cnt",  32'(matchCnt0), 32'(1));
    checkOutput("gap0Busy", 32'(busy0),     32'(0));

    // CNT_W=2 wrap: 3 then 6 matches -> 3 then 2
    applyStimulus(2, 8'hAA);
    for (int c = 0; c < 11; c++) tick();
    checkOutput("wrapCnt1", 32'(matchCntW), 32'(3));
    applyStimulus(2, 8'hAA);
    for (int c = 0; c < 11; c++) tick();
    checkOutput("wrapCnt2", 32'(matchCntW), 32'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter, the sending end of the bit-serial "101" detection path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first on a single-bit line. A fixed run of zero gap bits follows each word. A built-in overlapping "101" tracker counts the patterns the downstream detector must report, which gives an on-chip golden reference for link checks.

## Interface
- WIDTH, 8: bits per word; at least 2.
- GAP, 2: zero bits driven after each word's last bit; 0 is legal.
- CNT_W, 16: width of the match counter.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  WIDTH  word to transmit; sampled on accept.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block can accept a word.
- bit_out  out  1  serial line, registered; 0 when not shifting.
- busy  out  1  high in SHIFT or GAP.
- match_pulse  out  1  one-cycle pulse per "101" completed on bit_out.
- match_cnt  out  CNT_W  running count of "101" occurrences.

## Operation
- Transmit FSM states:
  - IDLE: data_ready=1, bit_out=0. Accept = data_valid && data_ready at a posedge. On accept, load the shift register, bit_out <= data_in[WIDTH-1], go to SHIFT.
  - SHIFT: emit the remaining bits MSB-first, one per cycle, for WIDTH cycles in total. After the LSB cycle, go to GAP if GAP>0, else IDLE.
  - GAP: bit_out=0 for exactly GAP cycles, then IDLE.
- data_ready is 1 only in IDLE. data_valid outside IDLE is ignored; data_in is not held or queued.
- Tracker FSM, one step per clk, input = current bit_out (mirrors a receiver sampling every cycle):
  - S0 on 1 -> S1; on 0 -> S0.
  - S1 on 0 -> S10; on 1 -> S1.
  - S10 on 1 -> S1 and match; on 0 -> S0.
- Overlapping: "10101" is 2 matches.
- The tracker runs in every state, including GAP and IDLE, so patterns spanning a word boundary count.
- On match, match_pulse <= 1 for one cycle and match_cnt <= match_cnt + 1, modulo 2^CNT_W (wraps, no saturation).
- Reset at any time, mid-word included:
  - transmit FSM -> IDLE; tracker -> S0;
  - bit_out=0, data_ready=1, busy=0, match_pulse=0, match_cnt=0;
  - the partial word is discarded.

## Timing
- Accept at edge k: bit_out carries bits WIDTH-1..0 during cycles k+1..k+WIDTH. GAP zeros follow in cycles k+WIDTH+1..k+WIDTH+GAP. IDLE starts at cycle k+WIDTH+GAP+1.
- Minimum word period: WIDTH+GAP+1 cycles. Between words there is always at least one IDLE zero in addition to the GAP zeros.
- busy=1 exactly during cycles k+1..k+WIDTH+GAP.
- Match latency: if the '1' completing a "101" is on bit_out in cycle c, then match_pulse=1 in cycle c+1 and match_cnt holds the incremented value from cycle c+1.
- Reset values of all outputs are listed under Operation.

## Structure
- Package seq_pattern_pkg:
  - tx_state_t enum {IDLE, SHIFT, GAP};
  - trk_state_t enum {S0, S1, S10};
  - a helper for the bit-counter width, $clog2(WIDTH) / $clog2(GAP+1).
- Sub-module seq101_tracker (clk, reset, bit_in, match_pulse, match_cnt; parameter CNT_W). It is reused by benches as a stand-alone reference model.
- Top-level holds the transmit FSM, shift register, and the bit and gap counters.

## Test plan
- Reset, then idle 5 cycles: bit_out=0, data_ready=1, busy=0, match_cnt=0 throughout.
- WIDTH=8, GAP=2, send 8'hAA:
  - bit_out = 1,0,1,0,1,0,1,0 in cycles k+1..k+8;
  - match_pulse in cycles k+4, k+6, k+8;
  - match_cnt=3; busy high for 10 cycles; data_ready returns at k+11.
- Back-to-back 8'h05 then 8'hA0, data_valid held high:
  - second accept occurs exactly 11 cycles after the first;
  - 1 match at the end of word 1 and 1 at bit 3 of word 2; match_cnt=2.
- GAP=0 instance, send 8'h01 then 8'h80 back-to-back: the stream "…1,0(idle),1…" yields a cross-boundary match; match_cnt=1.
- Assert reset at cycle k+4 of word 8'hFF: all outputs return to reset values immediately (asynchronous). The next accepted word transmits from its MSB, with no residue.
- CNT_W=2: send 8'hAA twice (6 matches): match_cnt wraps to 2.
